ctrl_unit_pipe: RTL and testbench

Registered, parametrised RV32I control unit with an optional RV32M multi-cycle sequencer. It sits at the ID/EX boundary of the pipelined core. It decodes a 32-bit instruction into a control bundle, registers it as the ID/EX control slice, and honours the hazard unit's stall and flush. MUL/DIV instructions hold the front end for a fixed number of cycles while the external MDU works.

---
 rtl/ctrl_pkg.sv | 59 +++++
 rtl/ctrl_unit_pipe_if.sv | 30 +++
 rtl/ctrl_decode_comb.sv | 78 +++++++
 rtl/ctrl_unit_pipe.sv | 92 +++++++++
 tb/tb_ctrl_unit_pipe.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU/immediate/result encodings and the control bundle for ctrl_unit_pipe
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  typedef enum logic {RUN, MDU_WAIT} state_t;
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [3:0] alu;
    logic       illegal;
    logic       is_m;
    logic [2:0] funct3;
  } ctrl_bundle_t;
  // alt selects SUB on funct3=000 and SRA on funct3=101
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt_add, input logic alt_shift);
    case (f3)
      3'b000:  alu_fn = alt_add ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt_shift ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_unit_pipe_if.sv
// ctrl_unit_pipe_if: instruction handshake, hazard controls and registered control bundle
interface ctrl_unit_pipe_if #(parameter int ALUCTRL_W = 4);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instr;
  logic                 stall_i;
  logic                 flush_i;
  logic                 out_valid;
  logic                 reg_write;
  logic                 alu_src;
  logic                 mem_write;
  logic                 branch;
  logic                 jump;
  logic [2:0]           imm_src;
  logic [1:0]           result_src;
  logic [ALUCTRL_W-1:0] alu_control;
  logic                 mdu_start;
  logic [2:0]           mdu_op;
  logic                 illegal;
  modport master (
    output in_valid, instr, stall_i, flush_i,
    input  in_ready, out_valid, reg_write, alu_src, mem_write, branch, jump,
           imm_src, result_src, alu_control, mdu_start, mdu_op, illegal
  );
  modport slave (
    input  in_valid, instr, stall_i, flush_i,
    output in_ready, out_valid, reg_write, alu_src, mem_write, branch, jump,
           imm_src, result_src, alu_control, mdu_start, mdu_op, illegal
  );
endinterface

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: combinational RV32I(+M when RV32M_EN) instruction to control-bundle decoder
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t bundle
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};
  always_comb begin
    bundle = '0;
    bundle.funct3 = f3;
    case (op)
      OP_R: begin
        bundle.reg_write = 1'b1;
        bundle.alu = alu_fn(f3, f7[5], f7[5]);
        if (f7 == F7_MULDIV) begin
`ifdef RV32M_EN
          bundle.is_m = 1'b1;
`else
          bundle.reg_write = 1'b0;
          bundle.illegal = 1'b1;
`endif
        end
      end
      OP_IMM: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.alu = alu_fn(f3, 1'b0, f7[5]);
      end
      OP_LOAD: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.result_src = RES_MEM;
      end
      OP_STORE: begin
        bundle.mem_write = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_S;
      end
      OP_BRANCH: begin
        bundle.branch = 1'b1;
        bundle.imm_src = IMM_B;
        bundle.alu = ALU_SUB;
      end
      OP_JAL: begin
        bundle.reg_write = 1'b1;
        bundle.jump = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_J;
        bundle.result_src = RES_PC4;
      end
      OP_JALR: begin
        bundle.reg_write = 1'b1;
        bundle.jump = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.result_src = RES_PC4;
      end
      OP_LUI: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_U;
        bundle.alu = ALU_PASSB;
      end
      OP_AUIPC: begin
        bundle.reg_write = 1'b1;
        bundle.alu_src = 1'b1;
        bundle.imm_src = IMM_U;
      end
      default: bundle.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: ID/EX control register with stall/flush and an RV32M wait sequencer.
// Define RV32M_EN to compile in the MUL/DIV path; otherwise M-extension words decode as illegal.
module ctrl_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W  = 4,
  parameter int MDU_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  ctrl_unit_pipe_if.slave bus
);
  ctrl_bundle_t dec;
  logic accept;
  ctrl_decode_comb u_dec (.instr(bus.instr), .bundle(dec));
  assign accept = bus.in_valid && bus.in_ready;
`ifdef RV32M_EN
  localparam int CW = $clog2(MDU_CYCLES + 1);
  state_t state;
  logic [CW-1:0] cnt;
  assign bus.in_ready = !rst && state == RUN && !bus.stall_i && !bus.flush_i;
`else
  logic unused_f3;
  assign unused_f3 = ^dec.funct3;
  assign bus.in_ready = !rst && !bus.stall_i && !bus.flush_i;
  assign bus.mdu_start = 1'b0;
  assign bus.mdu_op = 3'b000;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.alu_src <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.branch <= 1'b0;
      bus.jump <= 1'b0;
      bus.imm_src <= '0;
      bus.result_src <= '0;
      bus.alu_control <= '0;
      bus.illegal <= 1'b0;
`ifdef RV32M_EN
      bus.mdu_start <= 1'b0;
      bus.mdu_op <= '0;
      state <= RUN;
      cnt <= '0;
`endif
    end else if (bus.flush_i) begin
      bus.out_valid <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.branch <= 1'b0;
      bus.jump <= 1'b0;
      bus.illegal <= 1'b0;
`ifdef RV32M_EN
      bus.mdu_start <= 1'b0;
      state <= RUN;
      cnt <= '0;
`endif
    end else begin
`ifdef RV32M_EN
      bus.mdu_start <= accept && dec.is_m;
      // the counter runs down regardless of stall; only the final release waits on it
      if (state == MDU_WAIT) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else if (!bus.stall_i) begin
          bus.out_valid <= 1'b1;
          state <= RUN;
        end
      end else
`endif
      if (accept) begin
        bus.out_valid <= !dec.is_m;
        bus.reg_write <= dec.reg_write;
        bus.alu_src <= dec.alu_src;
        bus.mem_write <= dec.mem_write;
        bus.branch <= dec.branch;
        bus.jump <= dec.jump;
        bus.imm_src <= dec.imm_src;
        bus.result_src <= dec.result_src;
        bus.alu_control <= ALUCTRL_W'(dec.alu);
        bus.illegal <= dec.illegal;
`ifdef RV32M_EN
        if (dec.is_m) begin
          bus.mdu_op <= dec.funct3;
          cnt <= CW'(MDU_CYCLES - 1);
          state <= MDU_WAIT;
        end
`endif
      end else if (!bus.stall_i) bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb_ctrl_unit_pipe: directed self-checking bench for ctrl_unit_pipe (both RV32M_EN builds)
module tb_ctrl_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  ctrl_unit_pipe_if #(.ALUCTRL_W(4)) bus ();
  ctrl_unit_pipe #(.ALUCTRL_W(4), .MDU_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.instr = 32'h0;
  endtask

  task automatic test_reset();
    idle();
    #3;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", bus.in_ready); end
    checks++; if ({bus.reg_write, bus.mem_write, bus.branch, bus.jump, bus.illegal, bus.mdu_start} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {bus.reg_write, bus.mem_write, bus.branch, bus.jump, bus.illegal, bus.mdu_start}); end
    checks++; if (bus.alu_control !== 4'd0) begin errors++; $display("FAIL reset_alu got %0d exp 0", bus.alu_control); end
    #10 rst = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_add();
    bus.in_valid = 1'b1; bus.instr = 32'h002081B3;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0b exp 1", bus.out_valid); end
    checks++; if ({bus.reg_write, bus.alu_src, bus.result_src, bus.alu_control, bus.illegal} !== {1'b1, 1'b0, 2'b00, 4'd0, 1'b0}) begin errors++; $display("FAIL add_bundle got %b exp 10000000", {bus.reg_write, bus.alu_src, bus.result_src, bus.alu_control, bus.illegal}); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.in_valid = 1'b1; bus.instr = 32'h402081B3;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.alu_control !== 4'd1) begin errors++; $display("FAIL sub got valid %0b alu %0d exp 1 1", bus.out_valid, bus.alu_control); end
    bus.instr = 32'h0080A283;
    step();
    bus.in_valid = 1'b0;
    checks++; if ({bus.out_valid, bus.reg_write, bus.alu_src, bus.imm_src, bus.result_src, bus.alu_control} !== {1'b1, 1'b1, 1'b1, 3'b000, 2'b01, 4'd0}) begin errors++; $display("FAIL lw got %b exp 1110000010000", {bus.out_valid, bus.reg_write, bus.alu_src, bus.imm_src, bus.result_src, bus.alu_control}); end
    step();
  endtask

  task automatic test_decode();
    logic [31:0] words [9];
    logic [14:0] exp [9];
    logic [14:0] got;
    words = '{32'h0020A1B3, 32'h00208463, 32'h0020A423, 32'h123450B7, 32'h00000097,
              32'h008000EF, 32'h000080E7, 32'h4030D093, 32'h0020E1B3};
    exp = '{15'b1_0_0_0_0_000_00_0101_0, 15'b0_0_0_1_0_010_00_0001_0, 15'b0_1_1_0_0_001_00_0000_0,
            15'b1_1_0_0_0_011_00_1010_0, 15'b1_1_0_0_0_011_00_0000_0, 15'b1_1_0_0_1_100_10_0000_0,
            15'b1_1_0_0_1_000_10_0000_0, 15'b1_1_0_0_0_000_00_1001_0, 15'b1_0_0_0_0_000_00_0011_0};
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1; bus.instr = words[i];
      step();
      got = {bus.reg_write, bus.alu_src, bus.mem_write, bus.branch, bus.jump, bus.imm_src, bus.result_src, bus.alu_control, bus.illegal};
      checks++; if (got !== exp[i] || bus.out_valid !== 1'b1) begin errors++; $display("FAIL decode_%0d instr %h got %b valid %0b exp %b valid 1", i, words[i], got, bus.out_valid, exp[i]); end
    end
    idle();
    step();
  endtask

  task automatic test_stall();
    bus.in_valid = 1'b1; bus.instr = 32'h002081B3;
    step();
    bus.stall_i = 1'b1; bus.instr = 32'h0080A283;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d got %0b exp 0", i, bus.in_ready); end
      step();
      checks++; if ({bus.out_valid, bus.reg_write, bus.alu_src, bus.result_src} !== 5'b11000) begin errors++; $display("FAIL stall_hold_%0d got %b exp 11000", i, {bus.out_valid, bus.reg_write, bus.alu_src, bus.result_src}); end
    end
    idle();
    step();
  endtask

  task automatic test_mul();
    int low;
    bus.in_valid = 1'b1; bus.instr = 32'h022081B3;
    step();
    bus.in_valid = 1'b0;
`ifdef RV32M_EN
    low = 0;
    checks++; if (bus.mdu_start !== 1'b1 || bus.mdu_op !== 3'b000 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mul_launch got start %0b op %0d valid %0b exp 1 0 0", bus.mdu_start, bus.mdu_op, bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      if (bus.in_ready === 1'b0) low++;
      if (i > 0) begin
        checks++; if (bus.mdu_start !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mul_wait_%0d got start %0b valid %0b exp 0 0", i, bus.mdu_start, bus.out_valid); end
      end
      step();
    end
    checks++; if (low !== 4) begin errors++; $display("FAIL mul_ready_low got %0d exp 4", low); end
    checks++; if (bus.out_valid !== 1'b1 || bus.reg_write !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mul_done got valid %0b rw %0b ready %0b exp 1 1 1", bus.out_valid, bus.reg_write, bus.in_ready); end
`else
    checks++; if ({bus.out_valid, bus.illegal, bus.reg_write, bus.mdu_start} !== 4'b1100) begin errors++; $display("FAIL mul_illegal got %b exp 1100", {bus.out_valid, bus.illegal, bus.reg_write, bus.mdu_start}); end
`endif
    step();
  endtask

  task automatic test_mul_stall();
`ifdef RV32M_EN
    bus.in_valid = 1'b1; bus.instr = 32'h022081B3;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    bus.stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL mulstall_%0d got valid %0b ready %0b exp 0 0", i, bus.out_valid, bus.in_ready); end
    end
    bus.stall_i = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.reg_write !== 1'b1) begin errors++; $display("FAIL mulstall_done got valid %0b rw %0b exp 1 1", bus.out_valid, bus.reg_write); end
    step();
`endif
  endtask

  task automatic test_flush();
    bus.in_valid = 1'b1;
`ifdef RV32M_EN
    bus.instr = 32'h022081B3;
    step();
    bus.in_valid = 1'b0;
    step();
`else
    bus.instr = 32'h002081B3;
    step();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL preflush_valid got %0b exp 1", bus.out_valid); end
`endif
    bus.in_valid = 1'b1; bus.instr = 32'h0080A283; bus.flush_i = 1'b1; bus.stall_i = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", bus.in_ready); end
    step();
    checks++; if ({bus.out_valid, bus.reg_write, bus.mem_write, bus.branch, bus.jump, bus.illegal, bus.mdu_start} !== 7'b0) begin errors++; $display("FAIL flush_clear got %b exp 0000000", {bus.out_valid, bus.reg_write, bus.mem_write, bus.branch, bus.jump, bus.illegal, bus.mdu_start}); end
    idle();
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_run got %0b exp 1", bus.in_ready); end
    bus.in_valid = 1'b1; bus.instr = 32'h002081B3;
    step();
    idle();
    checks++; if (bus.out_valid !== 1'b1 || bus.reg_write !== 1'b1) begin errors++; $display("FAIL postflush_add got valid %0b rw %0b exp 1 1", bus.out_valid, bus.reg_write); end
    step();
  endtask

  task automatic test_illegal_reset();
    bus.in_valid = 1'b1; bus.instr = 32'hFFFFFFFF;
    step();
    checks++; if ({bus.out_valid, bus.illegal, bus.reg_write, bus.mem_write, bus.branch, bus.jump} !== 6'b110000) begin errors++; $display("FAIL illegal got %b exp 110000", {bus.out_valid, bus.illegal, bus.reg_write, bus.mem_write, bus.branch, bus.jump}); end
    bus.instr = 32'h022081B3;
    step();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.out_valid, bus.illegal, bus.reg_write, bus.mdu_start, bus.in_ready, bus.result_src, bus.alu_control, bus.mdu_op} !== 14'b0) begin errors++; $display("FAIL async_reset got %b exp 0", {bus.out_valid, bus.illegal, bus.reg_write, bus.mdu_start, bus.in_ready, bus.result_src, bus.alu_control, bus.mdu_op}); end
    #1 rst = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset got ready %0b valid %0b exp 1 0", bus.in_ready, bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_decode();
    test_stall();
    test_mul();
    test_mul_stall();
    test_flush();
    test_illegal_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
